// File: rtl/dsss_despreader.sv
// rtl/dsss_despreader.sv - DSSS despreader: serial-search PN acquisition, per-period correlation symbols
// Optional lock-loss counter output enabled by DSSS_LOCK_LOSS_CNT_EN.
module dsss_despreader #(
  parameter int          N        = 4,
  parameter int          ACC_W    = 20,
  parameter int unsigned THRESH   = 32768,
  parameter int          MISS_MAX = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [15:0]             in_data,
  output logic                    sym_valid,
  output logic [ACC_W-1:0]        sym_data,
  output logic                    locked,
  output logic [N-1:0]            slip_cnt,
  output logic                    chip_out
`ifdef DSSS_LOCK_LOSS_CNT_EN
  ,output logic [7:0]             lock_loss_cnt
`endif
);

  localparam int          MW       = $clog2(MISS_MAX + 1);
  localparam logic [N-1:0] LAST    = N'((1 << N) - 2);
  localparam logic [ACC_W-1:0] THR = ACC_W'(THRESH);
  localparam logic [ACC_W-1:0] MAXP = {1'b0, {(ACC_W-1){1'b1}}};

  typedef enum logic {SEARCH, LOCK} state_t;

  state_t                  state_q, state_d;
  logic [N-1:0]            lfsr_q, lfsr_d;
  logic [N-1:0]            cnt_q, cnt_d;
  logic [N-1:0]            slip_q, slip_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sym_q, sym_d;
  logic [MW-1:0]           miss_q, miss_d;
  logic                    slip_pend_q, slip_pend_d;
  logic                    symv_q, symv_d;

  logic                    chip;
  logic [15:0]             desp;
  logic signed [ACC_W-1:0] sum;
  logic [ACC_W-1:0]        mag;
  logic                    pass;
  logic [MW-1:0]           miss_inc;

  assign chip     = lfsr_q[N-1];
  assign desp     = chip ? ~in_data : in_data;
  assign sum      = acc_q + {{(ACC_W-16){desp[15]}}, desp};
  assign miss_inc = miss_q + MW'(1);

  // The most negative sum has no positive twin; clamp it to the largest magnitude.
  always_comb begin
    mag = sum;
    if (sum[ACC_W-1]) begin
      if (sum == {1'b1, {(ACC_W-1){1'b0}}}) mag = MAXP;
      else                                  mag = -sum;
    end
  end
  assign pass = (mag >= THR);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    slip_d      = slip_q;
    acc_d       = acc_q;
    sym_d       = sym_q;
    miss_d      = miss_q;
    slip_pend_d = slip_pend_q;
    symv_d      = 1'b0;
    if (in_valid) begin
      if (state_q == SEARCH && slip_pend_q) begin
        // Dropping one sample retards the local code by one chip.
        slip_pend_d = 1'b0;
        slip_d      = (slip_q == LAST) ? '0 : slip_q + N'(1);
      end else begin
        lfsr_d = {lfsr_q[N-2:0], lfsr_q[N-1] ^ lfsr_q[0]};
        if (cnt_q == LAST) begin
          cnt_d = '0;
          acc_d = '0;
          sym_d = sum;
          if (state_q == SEARCH) begin
            if (pass) begin
              state_d = LOCK;
              miss_d  = '0;
              symv_d  = 1'b1;
            end else begin
              slip_pend_d = 1'b1;
            end
          end else begin
            symv_d = 1'b1;
            if (pass) begin
              miss_d = '0;
            end else if (miss_inc == MW'(MISS_MAX)) begin
              state_d = SEARCH;
              slip_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end else begin
          cnt_d = cnt_q + N'(1);
          acc_d = sum;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      lfsr_q      <= '1;
      cnt_q       <= '0;
      slip_q      <= '0;
      acc_q       <= '0;
      sym_q       <= '0;
      miss_q      <= '0;
      slip_pend_q <= 1'b0;
      symv_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      slip_q      <= slip_d;
      acc_q       <= acc_d;
      sym_q       <= sym_d;
      miss_q      <= miss_d;
      slip_pend_q <= slip_pend_d;
      symv_q      <= symv_d;
    end
  end

  assign sym_valid = symv_q;
  assign sym_data  = sym_q;
  assign locked    = (state_q == LOCK);
  assign slip_cnt  = slip_q;
  assign chip_out  = chip;

`ifdef DSSS_LOCK_LOSS_CNT_EN
  logic [7:0] llc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      llc_q <= '0;
    end else if (state_q == LOCK && state_d == SEARCH && llc_q != 8'hFF) begin
      llc_q <= llc_q + 8'd1;
    end
  end
  assign lock_loss_cnt = llc_q;
`endif

endmodule

// File: tb/tb_dsss_despreader.sv
// tb/tb_dsss_despreader.sv - directed and randomized bench for dsss_despreader against a chip-index reference model
module tb_dsss_despreader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        sym_valid;
  logic [19:0] sym_data;
  logic        locked;
  logic [3:0]  slip_cnt;
  logic        chip_out;
`ifdef DSSS_LOCK_LOSS_CNT_EN
  logic [7:0]  lock_loss_cnt;
`endif

  dsss_despreader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .sym_valid(sym_valid), .sym_data(sym_data), .locked(locked),
    .slip_cnt(slip_cnt), .chip_out(chip_out)
`ifdef DSSS_LOCK_LOSS_CNT_EN
    , .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One period of the m-sequence produced from the all-ones seed.
  int p [15] = '{1, 1, 1, 1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0};

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: local code phase as an index into p, plain integer sums.
  int m_idx, m_cnt, m_acc, m_lock, m_miss, m_pend, m_slip, m_loss, m_sv, m_sd;
  int tx_i, tx_off;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_cnt = 0; m_acc = 0; m_lock = 0; m_miss = 0;
    m_pend = 0; m_slip = 0; m_loss = 0; m_sv = 0; m_sd = 0;
  endtask

  task automatic model_accept(input logic signed [15:0] x);
    int d, mag;
    if (!m_lock && m_pend) begin
      m_pend = 0;
      m_slip = (m_slip + 1) % 15;
      return;
    end
    d = p[m_idx] ? -int'(x) - 1 : int'(x);
    m_acc += d;
    m_idx = (m_idx + 1) % 15;
    if (m_cnt == 14) begin
      m_sd  = m_acc;
      m_acc = 0;
      m_cnt = 0;
      mag = (m_sd < 0) ? -m_sd : m_sd;
      if (mag > 524287) mag = 524287;
      if (!m_lock) begin
        if (mag >= 32768) begin m_lock = 1; m_miss = 0; m_sv = 1; end
        else m_pend = 1;
      end else begin
        m_sv = 1;
        if (mag >= 32768) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss == 3) begin
            m_lock = 0; m_slip = 0; m_miss = 0;
            if (m_loss < 255) m_loss++;
          end
        end
      end
    end else begin
      m_cnt++;
    end
  endtask

  task automatic step(input logic v, input logic [15:0] x);
    in_valid = v;
    in_data  = x;
    @(posedge clk);
    #1;
    m_sv = 0;
    if (v) model_accept(x);
    check("sym_valid", sym_valid, m_sv);
    check("locked", locked, m_lock);
    check("slip_cnt", slip_cnt, m_slip);
    check("chip_out", chip_out, p[m_idx]);
    if (m_sv != 0) check("sym_data", $signed(sym_data), m_sd);
`ifdef DSSS_LOCK_LOSS_CNT_EN
    check("lock_loss_cnt", lock_loss_cnt, m_loss);
`endif
  endtask

  // Transmitter: amplitude a with sign flipped by the code chip at (tx_i - tx_off).
  task automatic send(input int a, input int noise, input int gap);
    int c, val;
    for (int g = 0; g < gap; g++) step(1'b0, 16'($urandom));
    c   = p[((tx_i - tx_off) % 15 + 15) % 15];
    val = c ? -a - 1 : a;
    if (noise > 0) val += int'($urandom_range(0, 2 * noise)) - noise;
    step(1'b1, 16'(val));
    tx_i++;
  endtask

  task automatic do_reset(input logic v);
    rst = 1'b1;
    in_valid = v;
    in_data = 16'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    model_reset();
    tx_i = 0;
    tx_off = 0;
    check("rst_sym_valid", sym_valid, 0);
    check("rst_sym_data", $signed(sym_data), 0);
    check("rst_locked", locked, 0);
    check("rst_slip_cnt", slip_cnt, 0);
    check("rst_chip_out", chip_out, 1);
  endtask

  initial begin
    int lock_at, a, off;
    model_reset();
    tx_i = 0;
    tx_off = 0;

    do_reset(1'b0);

    // Aligned stream, back-to-back.
    for (int i = 0; i < 15; i++) send(4096, 0, 0);
    check("aligned_sym_valid", sym_valid, 1);
    check("aligned_sym_data", $signed(sym_data), 61440);
    check("aligned_locked", locked, 1);
    check("aligned_slip", slip_cnt, 0);
    for (int i = 0; i < 15; i++) send(4096, 0, 0);

    // Lock loss on an all-zero input.
    for (int i = 0; i < 45; i++) begin step(1'b1, 16'h0000); tx_i++; end
    check("loss_locked", locked, 0);
`ifdef DSSS_LOCK_LOSS_CNT_EN
    check("loss_cnt_one", lock_loss_cnt, 1);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 16'($urandom));

    // Three-chip phase offset: three failed dwells then lock on sample 63.
    do_reset(1'b0);
    tx_off = 3;
    lock_at = 0;
    for (int i = 1; i <= 63; i++) begin
      send(4096, 0, 0);
      if (i == 15) check("offset_dwell_sum", $signed(sym_data), -4104);
      if (locked && lock_at == 0) lock_at = i;
    end
    check("offset_lock_at", lock_at, 63);
    check("offset_slip_cnt", slip_cnt, 3);
    check("offset_sym_data", $signed(sym_data), 61440);

    // Gapped valid, every third cycle.
    do_reset(1'b0);
    for (int i = 0; i < 15; i++) send(4096, 0, 2);
    check("gapped_sym_valid", sym_valid, 1);
    check("gapped_sym_data", $signed(sym_data), 61440);
    check("gapped_locked", locked, 1);

    // Reset seven samples into a locked period, then relock.
    do_reset(1'b0);
    for (int i = 0; i < 22; i++) send(4096, 0, 0);
    do_reset(1'b1);
    for (int i = 0; i < 15; i++) send(4096, 0, 0);
    check("relock_sym_data", $signed(sym_data), 61440);
    check("relock_locked", locked, 1);

    // Negative full-scale input.
    do_reset(1'b0);
    for (int i = 0; i < 15; i++) send(-32768, 0, 0);
    check("negext_sym_data", $signed(sym_data), -491520);
    check("negext_locked", locked, 1);

    // Weak signal never locks; slip counter wraps through L-1.
    do_reset(1'b0);
    for (int i = 0; i < 256; i++) send(1000, 0, 0);
    check("weak_locked", locked, 0);

    // Randomized offsets, amplitudes, gaps and noise, then fade to noise only.
    for (int r = 0; r < 4; r++) begin
      do_reset(1'b0);
      tx_off = int'($urandom_range(0, 14));
      a = int'($urandom_range(3000, 20000));
      if ($urandom_range(0, 1) == 1) a = -a;
      off = tx_off;
      for (int i = 0; i < 300; i++)
        send(a, 200, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      check("rand_locked", locked, 1);
      check("rand_slip", slip_cnt, off);
      for (int i = 0; i < 60; i++) send(0, 300, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
